// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory port-B arbiter: arbitration state, read owner
// and the read-tag record that follows every issued read through the memory latency.
package mem_arb_pkg;

  typedef enum logic {
    VGA_PRI    = 1'b0,
    HOST_FORCE = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_VGA  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } read_tag_t;

  localparam read_tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_VGA};

  localparam int WAIT_W = 8;

endpackage

// File: rtl/read_tag_pipe.sv
// Delay line for read tags; its depth equals the port-B read latency so the tag
// leaves the last stage in the same cycle the memory presents the read data.
module read_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  read_tag_t tag_i,
  output read_tag_t tag_o
);

  read_tag_t stage_q [READ_LAT];

  // Clearing on reset drops in-flight reads so they never raise an rvalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < READ_LAT; i++) begin
        stage_q[i] <= TAG_IDLE;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < READ_LAT; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[READ_LAT-1];

endmodule

// File: rtl/mem_portb_arbiter.sv
// Shares data-memory port B between the VGA reader (fixed priority) and the host
// loader, with a starvation guard for the host and tagged return of read data.
module mem_portb_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 64,
  parameter int READ_LAT = 1,
  parameter int MAX_WAIT = 8,
  parameter int MISS_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [AW-1:0]     vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DW-1:0]     vga_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [AW-1:0]     host_addr,
  input  logic [DW-1:0]     host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DW-1:0]     host_rdata,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic              mem_we,
  input  logic [DW-1:0]     mem_rdata,
  output logic [MISS_W-1:0] vga_miss_cnt
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT - 1);

  arb_state_t        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              vga_win, host_win, host_denied;
  read_tag_t         issue_tag, ret_tag;

  // Grants are suppressed during the reset cycle so nothing reaches the memory.
  always_comb begin
    vga_win  = 1'b0;
    host_win = 1'b0;
    if (!reset) begin
      if (state_q == HOST_FORCE) begin
        host_win = host_req;
      end else begin
        vga_win  = vga_req;
        host_win = host_req & ~vga_req;
      end
    end
  end

  always_comb begin
    host_denied = host_req & ~host_win;
    state_d     = VGA_PRI;
    if ((state_q == VGA_PRI) && host_denied && (wait_q == WAIT_LIMIT)) begin
      state_d = HOST_FORCE;
    end
    wait_d = '0;
    if (host_denied) begin
      wait_d = (wait_q == '1) ? wait_q : wait_q + 1'b1;
    end
    miss_d = miss_q;
    if (vga_req && !vga_win && (miss_q != '1)) begin
      miss_d = miss_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= VGA_PRI;
      wait_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      miss_q  <= miss_d;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (vga_win) begin
      mem_addr = vga_addr;
    end else if (host_win) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_we    = host_we;
    end
  end

  always_comb begin
    issue_tag = TAG_IDLE;
    if (vga_win) begin
      issue_tag = '{valid: 1'b1, owner: OWN_VGA};
    end else if (host_win && !host_we) begin
      issue_tag = '{valid: 1'b1, owner: OWN_HOST};
    end
  end

  read_tag_pipe #(
    .READ_LAT(READ_LAT)
  ) u_tags (
    .clk   (clk),
    .reset (reset),
    .tag_i (issue_tag),
    .tag_o (ret_tag)
  );

  assign vga_gnt      = vga_win;
  assign host_gnt     = host_win;
  assign vga_rvalid   = ~reset & ret_tag.valid & (ret_tag.owner == OWN_VGA);
  assign host_rvalid  = ~reset & ret_tag.valid & (ret_tag.owner == OWN_HOST);
  assign vga_rdata    = reset ? '0 : mem_rdata;
  assign host_rdata   = reset ? '0 : mem_rdata;
  assign vga_miss_cnt = reset ? '0 : miss_q;

endmodule

// File: doc/mem_portb_arbiter.md
Name: mem_portb_arbiter

Overview:
- Shares the data memory's second port (port B: addressB / inputDataB / outB, plus write enable) between two requesters: the VGA image reader (read-only, latency-critical) and a host/image-loader channel (read/write, used to preload and read back frame data).
- Sits between the VGA path and dataMemory port B. Port A remains owned by the pipeline's MEMORY stage.
- Fixed VGA priority, with a starvation guard that forces one host grant after MAX_WAIT denied cycles.
- Tags every issued read so that read data returns to the correct requester.

Parameters:
- AW, 16, address width (matches ALUResult/addressB)
- DW, 64, data width (one vector/memory word)
- READ_LAT, 1, port-B read latency in cycles; legal range 1-4
- MAX_WAIT, 8, consecutive denied host cycles before a forced host grant; legal range 1-255
- MISS_W, 16, width of the VGA-denied counter

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- vga_req  in  1  VGA read request; address held stable until vga_gnt
- vga_addr  in  AW  VGA read address
- vga_gnt  out  1  VGA request accepted this cycle
- vga_rvalid  out  1  vga_rdata valid
- vga_rdata  out  DW  read data for VGA
- host_req  in  1  host request; host_we/addr/wdata held stable until host_gnt
- host_we  in  1  1 = write, 0 = read
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_gnt  out  1  host request accepted this cycle
- host_rvalid  out  1  host_rdata valid (reads only)
- host_rdata  out  DW  read data for host
- mem_addr  out  AW  to dataMemory addressB
- mem_wdata  out  DW  to dataMemory inputDataB
- mem_we  out  1  to dataMemory port-B write enable
- mem_rdata  in  DW  from dataMemory outB
- vga_miss_cnt  out  MISS_W  saturating count of cycles in which vga_req was denied

Behaviour:
- Reset (synchronous, active-high):
  - clears wait_cnt, FSM state, read-tag pipeline and vga_miss_cnt.
  - Outputs forced to 0 during the reset cycle, including gnt, rvalid and mem_we.
  - A reset mid-read discards the in-flight tags; no rvalid is produced for them.
- FSM states:
  - VGA_PRI (reset state): vga_req wins; the host is granted only when vga_req = 0.
  - HOST_FORCE: host granted unconditionally for exactly one cycle; vga_gnt = 0 even if vga_req = 1.
- Transitions:
  - VGA_PRI -> HOST_FORCE when the host is denied and wait_cnt reaches MAX_WAIT-1 in this cycle.
  - HOST_FORCE -> VGA_PRI always after one cycle.
- wait_cnt (8-bit):
  - Increments each cycle in which host_req = 1 and host_gnt = 0.
  - Clears on host_gnt or when host_req = 0.
  - Never wraps.
- Grant timing: combinational from registered state and the current requests; at most one gnt per cycle.
- mem_addr / mem_wdata / mem_we are muxed combinationally from the winner in the same cycle as gnt.
  - mem_we = host_gnt & host_we.
  - With no grant, mem_addr and mem_wdata hold 0 and mem_we = 0.
- Read tag pipeline: READ_LAT-deep shift register of {valid, owner}.
  - Stage 0 loads {1, VGA} on vga_gnt and {1, HOST} on host_gnt & ~host_we.
  - Otherwise stage 0 loads 0.
  - At the output stage, x_rvalid = valid & (owner == x).
  - Both rdata outputs are driven from mem_rdata; only the matching rvalid is asserted.
- Writes produce no rvalid.
- Back-to-back grants are allowed every cycle. Reads issued on consecutive cycles return in order, one per cycle.
- Same-address write then read: ordering is defined by the memory. The arbiter adds no forwarding.
- vga_miss_cnt increments when vga_req & ~vga_gnt and saturates at all-ones.
- Requester dropping req before gnt is legal; nothing is issued for it.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum {VGA_PRI, HOST_FORCE} arb_state_t
  - typedef enum logic {OWN_VGA, OWN_HOST} owner_t
  - struct read_tag_t {valid, owner}
- One sub-module, read_tag_pipe: the parameterised READ_LAT shift register of read_tag_t, with synchronous clear.

Test Plan:
- VGA-only reads at 0x0010 and 0x0011 on consecutive cycles (READ_LAT=1) -> vga_gnt both cycles; vga_rvalid on the next two cycles with the memory words; host_rvalid stays 0.
- Host write 0x0020 <- 0xDEADBEEF_01234567 with vga_req = 0 -> host_gnt and mem_we = 1 in the same cycle. A host read of 0x0020 next cycle -> host_rvalid one cycle later with that value.
- vga_req held high continuously, host read pending, MAX_WAIT=8 -> host denied 8 cycles; host_gnt on cycle 9 with vga_gnt = 0; VGA granted again on cycle 10; vga_miss_cnt = 1.
- Interleaved VGA read, host read, VGA read on three cycles with READ_LAT=3 -> rvalids return in order after 3 cycles and are routed to the correct owner.
- Reset asserted one cycle after a VGA grant with READ_LAT=2 -> no vga_rvalid for that read; all outputs 0 and wait_cnt 0 after reset.
- vga_req denied for 2^16+5 cycles (forced host grants each starvation window) -> vga_miss_cnt saturates at 0xFFFF.
